rsd_dec_pipe: RTL and testbench

- Registered, parametrised store-offset decoder for the RSD (register store destination) path of the instruction folding logic.
- Consumes a byte window from the instruction buffer and classifies xstore_n, xstore, iinc and wide-prefixed forms.
- Produces a one-hot offset select, the resolved local-variable offset, the instruction length and the store type one cycle later, behind a valid/ready handshake.
- A wide prefix may arrive alone in one window with its opcode in the next; a small state machine carries the prefix across windows.

---
 rtl/rsd_pkg.sv | 40 ++++
 rtl/rsd_classify.sv | 111 +++++++++++
 rtl/rsd_dec_pipe.sv | 118 +++++++++++
 tb/tb_rsd_dec_pipe.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/rsd_pkg.sv
// Shared opcode constants, result encodings and select-bit indices for the
// RSD store-offset decoder.
package rsd_pkg;

    localparam logic [7:0] OP_ISTORE   = 8'h36;
    localparam logic [7:0] OP_ASTORE   = 8'h3a;
    localparam logic [7:0] OP_ISTORE_0 = 8'h3b;
    localparam logic [7:0] OP_ASTORE_3 = 8'h4e;
    localparam logic [7:0] OP_IINC     = 8'h84;
    localparam logic [7:0] OP_WIDE     = 8'hc4;

    localparam int SEL_0    = 0;
    localparam int SEL_NEXT = 4;
    localparam int SEL_WIDE = 5;

    typedef enum logic [2:0] {
        RSD_NONE   = 3'd0,
        RSD_ISTORE = 3'd1,
        RSD_LSTORE = 3'd2,
        RSD_FSTORE = 3'd3,
        RSD_DSTORE = 3'd4,
        RSD_ASTORE = 3'd5,
        RSD_IINC   = 3'd6
    } rsd_type_e;

    typedef enum logic [0:0] {
        ST_IDLE      = 1'b0,
        ST_WIDE_PEND = 1'b1
    } rsd_state_e;

    // Indexed store opcodes 0x36..0x3a.
    function automatic logic is_store(input logic [7:0] op);
        return (op >= OP_ISTORE) && (op <= OP_ASTORE);
    endfunction

    function automatic rsd_type_e store_type(input logic [7:0] op);
        return rsd_type_e'(3'(op - OP_ISTORE + 8'd1));
    endfunction

endpackage

// File: rtl/rsd_classify.sv
// Combinational single-window classifier: decides select, offset, length and
// type for the current window, and whether enough bytes are valid to consume it.
module rsd_classify
    import rsd_pkg::*;
#(
    parameter int NBYTES       = 4,
    parameter int OFFW         = 16,
    parameter int SUPPORT_WIDE = 1
) (
    input  logic [8*NBYTES-1:0] opcode_win,
    input  logic [NBYTES-1:0]   valid_win,
    input  logic                wide_pend,
    output logic [5:0]          sel,
    output logic [OFFW-1:0]     offset,
    output logic [2:0]          len,
    output rsd_type_e           rtype,
    output logic                dbl,
    output logic                wide,
    output logic                enough,
    output logic                is_prefix
);

    logic [31:0] win_s;
    logic [5:0]  v_s;
    logic [7:0]  b0_s, b1_s, b2_s, b3_s;
    logic [7:0]  idx_s;

    // Bytes beyond NBYTES read as zero with their valid bits clear.
    assign win_s = 32'(opcode_win);
    assign v_s   = 6'(valid_win);
    assign b0_s  = win_s[7:0];
    assign b1_s  = win_s[15:8];
    assign b2_s  = win_s[23:16];
    assign b3_s  = win_s[31:24];
    assign idx_s = b0_s - OP_ISTORE_0;
    assign dbl   = (rtype == RSD_LSTORE) || (rtype == RSD_DSTORE);

    // Per-rule decode of the window, selected by whether a wide prefix is pending.
    always_comb begin
        sel        = 6'd0;
        sel[SEL_0] = 1'b1;
        offset     = '0;
        len        = 3'd0;
        rtype      = RSD_NONE;
        wide       = 1'b0;
        enough     = 1'b0;
        is_prefix  = 1'b0;
        if (!wide_pend) begin
            if ((b0_s >= OP_ISTORE_0) && (b0_s <= OP_ASTORE_3)) begin
                // xstore_<n>: five families of four, n in the low two index bits
                enough = v_s[0];
                len    = 3'd1;
                rtype  = rsd_type_e'(3'(idx_s[4:2]) + 3'd1);
                sel    = 6'd1 << idx_s[1:0];
                offset = OFFW'(idx_s[1:0]);
            end else if (is_store(b0_s)) begin
                enough         = &v_s[1:0];
                len            = 3'd2;
                rtype          = store_type(b0_s);
                sel            = 6'd0;
                sel[SEL_NEXT]  = 1'b1;
                offset         = OFFW'(b1_s);
            end else if (b0_s == OP_IINC) begin
                enough         = &v_s[2:0];
                len            = 3'd3;
                rtype          = RSD_IINC;
                sel            = 6'd0;
                sel[SEL_NEXT]  = 1'b1;
                offset         = OFFW'(b1_s);
            end else if ((b0_s == OP_WIDE) && (SUPPORT_WIDE != 0)) begin
                if ((&v_s[3:0]) && is_store(b1_s)) begin
                    enough        = 1'b1;
                    len           = 3'd4;
                    rtype         = store_type(b1_s);
                    sel           = 6'd0;
                    sel[SEL_WIDE] = 1'b1;
                    offset        = OFFW'({b2_s, b3_s});
                    wide          = 1'b1;
                end else if ((&v_s[5:0]) && (b1_s == OP_IINC)) begin
                    enough        = 1'b1;
                    len           = 3'd6;
                    rtype         = RSD_IINC;
                    sel           = 6'd0;
                    sel[SEL_WIDE] = 1'b1;
                    offset        = OFFW'({b2_s, b3_s});
                    wide          = 1'b1;
                end else begin
                    // lone prefix: consume it and decode the opcode next window
                    enough    = v_s[0];
                    len       = 3'd1;
                    is_prefix = 1'b1;
                end
            end else begin
                enough = v_s[0];
            end
        end else begin
            wide = 1'b1;
            if (is_store(b0_s) || (b0_s == OP_IINC)) begin
                enough        = &v_s[2:0];
                len           = (b0_s == OP_IINC) ? 3'd5 : 3'd3;
                rtype         = (b0_s == OP_IINC) ? RSD_IINC : store_type(b0_s);
                sel           = 6'd0;
                sel[SEL_WIDE] = 1'b1;
                offset        = OFFW'({b1_s, b2_s});
            end else begin
                enough = v_s[0];
            end
        end
    end

endmodule

// File: rtl/rsd_dec_pipe.sv
// Registered RSD store-offset decoder: wide-prefix state machine, valid/ready
// handshake and the output register around rsd_classify.
module rsd_dec_pipe
    import rsd_pkg::*;
#(
    parameter int NBYTES       = 4,
    parameter int OFFW         = 16,
    parameter int SUPPORT_WIDE = 1
) (
    input  logic                clk,
    input  logic                reset_l,
    input  logic                flush,
    input  logic [8*NBYTES-1:0] opcode_win,
    input  logic [NBYTES-1:0]   valid_win,
    input  logic                dec_req,
    output logic                dec_ack,
    output logic [2:0]          dec_len,
    output logic                rsd_vld,
    input  logic                rsd_rdy,
    output logic [5:0]          offset_sel_rsd,
    output logic [OFFW-1:0]     rsd_offset,
    output logic [2:0]          rsd_type,
    output logic                rsd_dbl,
    output logic                rsd_wide
);

    rsd_state_e      state_r, state_nxt_s;
    logic [5:0]      sel_s, sel_r;
    logic [OFFW-1:0] offset_s, offset_r;
    logic [2:0]      len_s;
    rsd_type_e       type_s, type_r;
    logic            dbl_s, dbl_r, wide_s, wide_r, vld_r;
    logic            enough_s, is_prefix_s, space_s, ack_s, load_s;

    rsd_classify #(
        .NBYTES       (NBYTES),
        .OFFW         (OFFW),
        .SUPPORT_WIDE (SUPPORT_WIDE)
    ) u_classify (
        .opcode_win (opcode_win),
        .valid_win  (valid_win),
        .wide_pend  (state_r == ST_WIDE_PEND),
        .sel        (sel_s),
        .offset     (offset_s),
        .len        (len_s),
        .rtype      (type_s),
        .dbl        (dbl_s),
        .wide       (wide_s),
        .enough     (enough_s),
        .is_prefix  (is_prefix_s)
    );

    assign space_s = !vld_r || rsd_rdy;
    assign ack_s   = reset_l && dec_req && !flush && space_s && enough_s;
    assign load_s  = ack_s && !is_prefix_s;

    assign dec_ack        = ack_s;
    assign dec_len        = len_s;
    assign rsd_vld        = vld_r;
    assign offset_sel_rsd = sel_r;
    assign rsd_offset     = offset_r;
    assign rsd_type       = type_r;
    assign rsd_dbl        = dbl_r;
    assign rsd_wide       = wide_r;

    // Prefix state register.
    always_ff @(posedge clk) begin
        if (!reset_l) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state: enter WIDE_PEND on a consumed lone prefix, leave on any consumed window.
    always_comb begin
        state_nxt_s = state_r;
        if (flush) begin
            state_nxt_s = ST_IDLE;
        end else if (ack_s) begin
            case (state_r)
                ST_IDLE:      state_nxt_s = is_prefix_s ? ST_WIDE_PEND : ST_IDLE;
                ST_WIDE_PEND: state_nxt_s = ST_IDLE;
                default:      state_nxt_s = ST_IDLE;
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Output register; data fields only change on a load so they hold under backpressure.
    always_ff @(posedge clk) begin
        if (!reset_l) begin
            vld_r    <= 1'b0;
            sel_r    <= 6'b000001;
            offset_r <= '0;
            type_r   <= RSD_NONE;
            dbl_r    <= 1'b0;
            wide_r   <= 1'b0;
        end else begin
            if (flush) begin
                vld_r <= 1'b0;
            end else if (load_s) begin
                vld_r <= 1'b1;
            end else if (rsd_rdy) begin
                vld_r <= 1'b0;
            end
            if (load_s) begin
                sel_r    <= sel_s;
                offset_r <= offset_s;
                type_r   <= type_s;
                dbl_r    <= dbl_s;
                wide_r   <= wide_s;
            end
        end
    end

endmodule

// File: tb/tb_rsd_dec_pipe.sv
// Scoreboard bench for rsd_dec_pipe: directed test-plan windows followed by
// randomized traffic, checked against an opcode-table reference model.
module tb_rsd_dec_pipe;

    logic        clk = 1'b0;
    logic        reset_l = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] opcode_win = 32'd0;
    logic [3:0]  valid_win = 4'd0;
    logic        dec_req = 1'b0;
    logic        dec_ack;
    logic [2:0]  dec_len;
    logic        rsd_vld;
    logic        rsd_rdy = 1'b1;
    logic [5:0]  offset_sel_rsd;
    logic [15:0] rsd_offset;
    logic [2:0]  rsd_type;
    logic        rsd_dbl;
    logic        rsd_wide;

    rsd_dec_pipe #(.NBYTES(4), .OFFW(16), .SUPPORT_WIDE(1)) dut (
        .clk(clk), .reset_l(reset_l), .flush(flush), .opcode_win(opcode_win),
        .valid_win(valid_win), .dec_req(dec_req), .dec_ack(dec_ack), .dec_len(dec_len),
        .rsd_vld(rsd_vld), .rsd_rdy(rsd_rdy), .offset_sel_rsd(offset_sel_rsd),
        .rsd_offset(rsd_offset), .rsd_type(rsd_type), .rsd_dbl(rsd_dbl), .rsd_wide(rsd_wide)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          ok;
        bit          pre;
        int          len;
        logic [5:0]  sel;
        logic [15:0] off;
        int          typ;
        bit          dbl;
        bit          wide;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   vld_m  = 1'b0;
    bit   pend_m = 1'b0;
    localparam int NB = 4;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: opcode families from the JVM table; vc = count of valid bytes.
    function automatic exp_t model(input bit pend, input logic [7:0] b[4], input int vc);
        exp_t e;
        int   op = int'(b[0]);
        int   b1 = int'(b[1]);
        e = '{ok: 1'b0, pre: 1'b0, len: 0, sel: 6'b000001, off: 16'd0, typ: 0, dbl: 1'b0, wide: pend};
        if (pend) begin
            if ((op >= 'h36 && op <= 'h3a) || op == 'h84) begin
                e.ok  = vc >= 3;
                e.len = (op == 'h84) ? 5 : 3;
                e.typ = (op == 'h84) ? 6 : op - 'h35;
                e.sel = 6'b100000;
                e.off = 16'(int'(b[1]) * 256 + int'(b[2]));
            end else begin
                e.ok = vc >= 1;
            end
        end else if (op >= 'h3b && op <= 'h4e) begin
            e.ok  = vc >= 1;
            e.len = 1;
            e.typ = (op - 'h3b) / 4 + 1;
            e.off = 16'((op - 'h3b) % 4);
            e.sel = 6'b000001 << ((op - 'h3b) % 4);
        end else if (op >= 'h36 && op <= 'h3a) begin
            e.ok = vc >= 2; e.len = 2; e.typ = op - 'h35; e.sel = 6'b010000; e.off = 16'(b1);
        end else if (op == 'h84) begin
            e.ok = vc >= 3; e.len = 3; e.typ = 6; e.sel = 6'b010000; e.off = 16'(b1);
        end else if (op == 'hc4) begin
            if (vc >= 4 && b1 >= 'h36 && b1 <= 'h3a) begin
                e.ok = 1'b1; e.len = 4; e.typ = b1 - 'h35; e.sel = 6'b100000; e.wide = 1'b1;
                e.off = 16'(int'(b[2]) * 256 + int'(b[3]));
            end else if (NB >= 6 && vc >= 6 && b1 == 'h84) begin
                e.ok = 1'b1; e.len = 6; e.typ = 6; e.sel = 6'b100000; e.wide = 1'b1;
                e.off = 16'(int'(b[2]) * 256 + int'(b[3]));
            end else begin
                e.ok = vc >= 1; e.len = 1; e.pre = 1'b1;
            end
        end else begin
            e.ok = vc >= 1;
        end
        e.dbl = (e.typ == 2) || (e.typ == 4);
        return e;
    endfunction

    // One cycle of stimulus plus handshake check and scoreboard update.
    task automatic step(input bit req, input bit fl, input bit rdy, input logic [7:0] b0,
                        input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3, input int vc);
        logic [7:0] b[4];
        exp_t       e;
        bit         exp_ack;
        b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
        @(posedge clk);
        #1;
        dec_req    = req;
        flush      = fl;
        rsd_rdy    = rdy;
        opcode_win = {b3, b2, b1, b0};
        valid_win  = 4'((1 << vc) - 1);
        @(negedge clk);
        #1;
        e       = model(pend_m, b, vc);
        exp_ack = req && !fl && (!vld_m || rdy) && e.ok;
        chk("dec_ack", 32'(dec_ack), 32'(exp_ack));
        if (exp_ack) chk("dec_len", 32'(dec_len), 32'(e.len));
        if (fl && vld_m && !rdy && q.size() > 0) void'(q.pop_back());
        if (exp_ack && !e.pre) q.push_back(e);
        vld_m  = fl ? 1'b0 : (exp_ack && !e.pre) ? 1'b1 : rdy ? 1'b0 : vld_m;
        pend_m = fl ? 1'b0 : exp_ack ? (!pend_m && e.pre) : pend_m;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset_l = 1'b0; dec_req = 1'b1; flush = 1'b0; rsd_rdy = 1'b1;
        opcode_win = 32'h0000003d; valid_win = 4'hf;
        @(negedge clk);
        chk("ack_in_reset", 32'(dec_ack), 32'd0);
        @(posedge clk);
        #1;
        reset_l = 1'b1; dec_req = 1'b0;
        q.delete(); vld_m = 1'b0; pend_m = 1'b0;
        @(negedge clk);
        chk("reset_out", {5'd0, rsd_vld, rsd_type, rsd_dbl, rsd_wide, offset_sel_rsd, rsd_offset},
            {5'd0, 1'b0, 3'd0, 1'b0, 1'b0, 6'b000001, 16'd0});
    endtask

    // Monitor: every accepted result is compared with the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_l === 1'b1 && rsd_vld === 1'b1 && rsd_rdy === 1'b1) begin
                if (q.size() == 0) begin
                    chk("unexpected_result", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("result", {5'd0, rsd_type, rsd_dbl, rsd_wide, offset_sel_rsd, rsd_offset},
                        {5'd0, 3'(e.typ), e.dbl, e.wide, e.sel, e.off});
                end
            end
        end
    end

    function automatic logic [7:0] rand_op();
        int p = int'($urandom_range(0, 9));
        if (p <= 3) return 8'(8'h3b + 8'($urandom_range(0, 19)));
        if (p <= 5) return 8'(8'h36 + 8'($urandom_range(0, 4)));
        if (p == 6) return 8'h84;
        if (p <= 8) return 8'hc4;
        return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        do_reset();
        // Directed windows
        step(1, 0, 1, 8'h3d, 8'h00, 8'h00, 8'h00, 1);
        step(1, 0, 1, 8'h39, 8'h7f, 8'h00, 8'h00, 2);
        step(1, 0, 1, 8'h39, 8'h55, 8'h00, 8'h00, 1);
        step(1, 0, 1, 8'h39, 8'h55, 8'h00, 8'h00, 2);
        step(1, 0, 1, 8'hc4, 8'h36, 8'h12, 8'h34, 4);
        step(1, 0, 1, 8'hc4, 8'h00, 8'h00, 8'h00, 1);
        step(1, 0, 1, 8'h3a, 8'h01, 8'h00, 8'h00, 3);
        step(1, 0, 1, 8'h84, 8'h09, 8'h05, 8'h00, 3);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 8'h4c, 8'h00, 8'h00, 8'h00, 1);
        step(1, 0, 1, 8'h4c, 8'h00, 8'h00, 8'h00, 1);
        step(1, 0, 1, 8'hc4, 8'h00, 8'h00, 8'h00, 1);
        step(1, 1, 1, 8'h3d, 8'h00, 8'h00, 8'h00, 1);
        step(1, 0, 1, 8'h3d, 8'h00, 8'h00, 8'h00, 1);
        step(1, 0, 1, 8'hc4, 8'h84, 8'h01, 8'h02, 4);
        step(1, 0, 1, 8'h84, 8'h01, 8'h02, 8'h03, 3);
        step(1, 0, 1, 8'hc4, 8'h00, 8'h00, 8'h00, 1);
        do_reset();
        step(1, 0, 1, 8'h3d, 8'h00, 8'h00, 8'h00, 1);
        step(1, 0, 1, 8'h10, 8'h00, 8'h00, 8'h00, 1);
        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [7:0] b1;
            int         p = int'($urandom_range(0, 9));
            b1 = (p <= 4) ? 8'(8'h36 + 8'($urandom_range(0, 4))) : (p <= 6) ? 8'h84 : 8'($urandom_range(0, 255));
            step($urandom_range(0, 99) < 85, $urandom_range(0, 19) == 0, $urandom_range(0, 99) < 70,
                 rand_op(), b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 int'($urandom_range(0, 4)));
        end
        for (int i = 0; i < 4; i++) step(0, 0, 1, 8'h00, 8'h00, 8'h00, 8'h00, 0);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
